// File: rtl/sram_access_controller_pkg.sv
// Shared definitions for the SRAM access controller: bus widths, default base address,
// FSM state type and the byte-address to word-offset helper.
package sram_access_controller_pkg;

  localparam int unsigned SRAM_ADDR_W       = 18;
  localparam int unsigned SRAM_DATA_W       = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  // Callers truncate the result to the word-index width, which gives the address wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_access_controller_if.sv
// MEM-stage load/store handshake between the pipeline and the SRAM access controller.
interface sram_access_controller_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready, freeze
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready, freeze
  );

endinterface

// File: rtl/sram_access_controller_wait_counter.sv
// Per-phase wait-state down-counter: reloads WAIT_CYCLES on phase entry, last_o at zero.
module sram_access_controller_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(WAIT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_controller.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit SRAM
// accesses (low half then high half) with fixed wait states; freeze stalls the pipeline.
module sram_access_controller
  import sram_access_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_access_controller_if.slave bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic                   sram_we_n
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   is_wr_q, is_wr_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   dq_oe_q, dq_oe_d;
  logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
  logic                   req;
  logic                   cnt_load;
  logic                   cnt_last;

  assign req = bus.mem_read | bus.mem_write;

  sram_access_controller_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d    = IDX_W'(word_index(bus.address, BASE_ADDR));
          wdata_d  = bus.write_data;
          is_wr_d  = bus.mem_write;
          cnt_load = 1'b1;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_last) begin
          if (!is_wr_q) rdata_d[15:0] = sram_dq;
          cnt_load = 1'b1;
          state_d  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_last) begin
          if (!is_wr_q) rdata_d[31:16] = sram_dq;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin registers are computed from the next state so they line up with the phase itself.
  always_comb begin
    addr_d   = '0;
    we_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = '0;
    unique case (state_d)
      ST_LOW: begin
        addr_d   = SRAM_ADDR_W'({idx_d, 1'b0});
        we_n_d   = ~is_wr_d;
        dq_oe_d  = is_wr_d;
        dq_out_d = wdata_d[15:0];
      end
      ST_HIGH: begin
        addr_d   = SRAM_ADDR_W'({idx_d, 1'b1});
        we_n_d   = ~is_wr_d;
        dq_oe_d  = is_wr_d;
        dq_out_d = wdata_d[31:16];
      end
      default: begin
        addr_d   = '0;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign sram_dq   = dq_oe_q ? dq_out_q : 'z;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;

  assign bus.read_data = rdata_q;
  assign bus.ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign bus.freeze    = req & ~bus.ready;

endmodule
